// File: rtl/fetch_stage_pkg.sv
// fetch_types: shared state, constant and packet types for the instruction fetch stage
package fetch_types;
  typedef enum logic [1:0] {REQ, WAIT, DRAIN} fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_stage_skid.sv
// fetch_skid_buf: one-entry holding buffer for a fetched packet while decode stalls
module fetch_skid_buf
  import fetch_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       unload_i,
  input  logic       clear_i,
  input  fetch_pkt_t pkt_i,
  output fetch_pkt_t pkt_o,
  output logic       full_o
);
  fetch_pkt_t data_q, data_d;
  logic       full_q, full_d;
  always_comb begin
    full_d = clear_i ? 1'b0 : load_i ? 1'b1 : unload_i ? 1'b0 : full_q;
    data_d = (load_i && !clear_i) ? pkt_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign pkt_o  = data_q;
  assign full_o = full_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, single-outstanding instruction fetch and IF/ID pipeline register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4
);
  import fetch_types::*;
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d, ipc_q, ipc_d, ipc4_q, ipc4_d;
  logic         fetch_ok, take_direct, skid_load, skid_unload, skid_full, busy;
  fetch_pkt_t   skid_pkt;
  assign imem_req  = rst_n && state_q == REQ && !skid_full;
  assign imem_addr = pc_q & 32'hFFFF_FFFC;
  always_comb begin
    fetch_ok    = imem_rvalid && state_q == WAIT && !redirect_valid;
    take_direct = fetch_ok && (!valid_q || !stall) && !skid_full;
    skid_load   = fetch_ok && !take_direct;
    skid_unload = !redirect_valid && !stall && skid_full;
    // a response is still owed by memory after this edge: it must be drained
    busy        = ((state_q == WAIT || state_q == DRAIN) && !imem_rvalid) || (imem_req && imem_gnt);
    state_d     = redirect_valid ? (busy ? DRAIN : REQ) :
                  state_q == REQ ? ((imem_req && imem_gnt) ? WAIT : REQ) :
                  imem_rvalid    ? REQ : state_q;
    pc_d        = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : fetch_ok ? pc_q + 32'd4 : pc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    ipc4_d      = ipc4_q;
    if (redirect_valid) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (skid_unload) begin
      valid_d = 1'b1;
      instr_d = skid_pkt.instr;
      ipc_d   = skid_pkt.pc;
      ipc4_d  = skid_pkt.pc + 32'd4;
    end else if (take_direct) begin
      valid_d = 1'b1;
      instr_d = imem_rdata;
      ipc_d   = pc_q;
      ipc4_d  = pc_q + 32'd4;
    end else if (!stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      ipc4_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
    end
  end
  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (redirect_valid),
    .pkt_i    ('{pc: pc_q, instr: imem_rdata}),
    .pkt_o    (skid_pkt),
    .full_o   (skid_full)
  );
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign if_id_pc4   = ipc4_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench; a decode model consumes IF/ID and checks it against the fetch order
module tb_fetch_stage;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WPC = 32'hFFFF_FFF8;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_rvalid, imem_gnt = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;
  logic        w_req, w_valid, w_rvalid = 1'b0;
  logic [31:0] w_addr, w_rdata = '0, w_instr, w_pc, w_pc4;
  int          n_tests = 0, n_fail = 0;
  int          lat = 1, wn = 0;
  logic        gnt_rand = 1'b0, hold_pend = 1'b0;
  logic [31:0] hold_addr = '0, exp_pc = '0;
  logic [31:0] sb[$];
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_a = '0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4));

  fetch_stage #(.RESET_PC(WPC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .if_id_valid(w_valid),
    .if_id_instr(w_instr), .if_id_pc(w_pc), .if_id_pc4(w_pc4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory: response lat cycles after grant, data derived from the address
  always @(posedge clk) begin
    if (mem_busy && mem_cnt <= 1) mem_busy <= 1'b0;
    else if (mem_busy) mem_cnt <= mem_cnt - 1;
    if (imem_req && imem_gnt) begin
      mem_busy <= 1'b1;
      mem_cnt  <= lat;
      mem_a    <= imem_addr;
    end
  end
  assign imem_rvalid = mem_busy && mem_cnt == 1;
  assign imem_rdata  = mem_a ^ KEY;

  always @(posedge clk) begin
    w_rvalid <= w_req;
    w_rdata  <= w_addr ^ KEY;
  end

  always @(posedge clk) begin
    #1;
    imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      sb.delete();
      exp_pc = 32'h0;
      wn = 0;
      chk("req_in_reset", imem_req, 0);
    end else begin
      if (!if_id_valid) chk("nop_when_invalid", if_id_instr, NOP);
      if (if_id_valid && !stall) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("if_id_pc", if_id_pc, e);
          chk("if_id_instr", if_id_instr, e ^ KEY);
          chk("if_id_pc4", if_id_pc4, e + 32'd4);
        end
      end
      if (hold_pend) begin
        chk("req_hold", imem_req, 1);
        chk("addr_hold", imem_addr, hold_addr);
      end
      if (imem_req && imem_gnt) begin
        chk("fetch_addr", imem_addr, exp_pc);
        sb.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) begin
        sb.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      if (w_valid && wn < 3) begin
        chk("wrap_pc", w_pc, WPC + 32'(4 * wn));
        chk("wrap_pc4", w_pc4, WPC + 32'(4 * wn + 4));
        chk("wrap_instr", w_instr, (WPC + 32'(4 * wn)) ^ KEY);
        wn++;
      end
    end
    hold_pend = rst_n && imem_req && !imem_gnt && !redirect_valid;
    hold_addr = imem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) break;
    end
    chk("gnt_timeout", i < 50, 1);
    tick();
  endtask

  initial begin
    logic [31:0] pc0;
    int nrv;
    tick();
    tick();
    chk("rst_valid", if_id_valid, 0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc", if_id_pc, 0);
    chk("rst_pc4", if_id_pc4, 0);
    chk("rst_req", imem_req, 0);
    rst_n = 1'b1;
    repeat (20) tick();
    // stall mid-stream: start in a REQ cycle with a live IF/ID entry
    wait_gnt();
    tick();
    chk("stall_start_valid", if_id_valid, 1);
    pc0 = if_id_pc;
    stall = 1'b1;
    nrv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stall_frozen_pc", if_id_pc, pc0);
      chk("stall_frozen_valid", if_id_valid, 1);
      if (k >= 1) chk("req_while_skid_full", imem_req, 0);
      if (imem_rvalid) nrv++;
      tick();
    end
    chk("stall_words_captured", nrv, 1);
    stall = 1'b0;
    repeat (10) tick();
    gnt_rand = 1'b1;
    repeat (40) tick();
    gnt_rand = 1'b0;
    repeat (4) tick();
    // redirect while waiting on a slow response
    lat = 3;
    repeat (6) tick();
    wait_gnt();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", if_id_valid, 0);
    chk("drain_req", imem_req, 0);
    tick();
    tick();
    @(negedge clk);
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    lat = 1;
    repeat (10) tick();
    // redirect in the same cycle as the response
    wait_gnt();
    chk("redir_rvalid_same", imem_rvalid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0204;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir1_req", imem_req, 1);
    chk("redir1_addr", imem_addr, 32'h0000_0204);
    chk("redir1_valid", if_id_valid, 0);
    repeat (10) tick();
    // redirect while stalled with the skid full
    wait_gnt();
    tick();
    stall = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0301;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("stall_flush_valid", if_id_valid, 0);
    chk("stall_flush_req", imem_req, 1);
    chk("stall_flush_addr", imem_addr, 32'h0000_0300);
    tick();
    stall = 1'b0;
    repeat (12) tick();
    // reset pulse during WAIT; the old response lands after reset
    lat = 2;
    repeat (6) tick();
    wait_gnt();
    rst_n = 1'b0;
    tick();
    chk("rst2_valid", if_id_valid, 0);
    chk("rst2_instr", if_id_instr, NOP);
    chk("rst2_pc", if_id_pc, 0);
    chk("rst2_pc4", if_id_pc4, 0);
    chk("rst2_req", imem_req, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_stale_rvalid", imem_rvalid, 1);
    chk("rst2_first_addr", imem_addr, 32'h0);
    tick();
    lat = 1;
    repeat (20) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage plus IF/ID pipeline register for the 5-stage RV32I core. It owns the PC and issues word fetches over a single-outstanding request/grant/response handshake. It delivers {pc, pc+4, instr} to decode, where instr feeds the opcode decoder and immgen. It honours decode stall and EX redirect (taken branch/jump), and discards stale in-flight responses after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instr value presented to decode when if_id_valid=0 (addi x0,x0,0)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch word address, bits [1:0] always 0
imem_gnt  in  1  request accepted this cycle (imem_req && imem_gnt = handshake)
imem_rvalid  in  1  response data valid; earliest the cycle after grant
imem_rdata  in  32  fetched instruction word
stall  in  1  decode cannot accept; hold IF/ID contents
redirect_valid  in  1  EX taken branch/jump; flush and refetch
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
if_id_valid  out  1  IF/ID slot holds a live instruction
if_id_instr  out  32  instruction word (NOP_INSTR when invalid)
if_id_pc  out  32  PC of if_id_instr
if_id_pc4  out  32  if_id_pc + 4, modulo 2^32

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, state=REQ, skid empty, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0; imem_req=0 during reset.
- States: REQ (drive imem_req=1, imem_addr=pc), WAIT (one request outstanding), DRAIN (outstanding response is stale, discard).
- REQ: req asserted only if skid empty. On gnt -> WAIT; imem_req must stay high with stable addr until gnt.
- WAIT on rvalid: tag {pc, rdata}; if !if_id_valid or !stall, load IF/ID directly; else load skid. pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0). -> REQ.
- rvalid accepted only in WAIT/DRAIN; ignored otherwise (incl. first cycle after reset).
- stall=1: IF/ID outputs frozen. stall=0 and skid full: skid -> IF/ID, skid empties; a same-cycle rvalid goes into skid (skid never overflows because no request issues while skid is full).
- stall=0, skid empty, no rvalid: if_id_valid<=0 (bubble), if_id_instr<=NOP_INSTR.
- redirect_valid (priority over stall and rvalid): if_id_valid<=0, instr<=NOP_INSTR, skid cleared, pc<=redirect_pc. Next state: WAIT with no same-cycle rvalid -> DRAIN; REQ with gnt this cycle -> DRAIN; otherwise REQ. A response arriving in the redirect cycle is discarded.
- DRAIN: imem_req=0; on rvalid discard data -> REQ. A further redirect in DRAIN updates pc and stays in DRAIN.
- Redirect-to-first-fetch latency: 1 cycle to imem_req (REQ case).
- Throughput: one instruction per 2 cycles with 1-cycle memory (REQ/gnt, then rvalid). Pipelined fetch is out of scope.

Decomposition:
- Package fetch_types: fetch_state_e {REQ, WAIT, DRAIN}, NOP_INSTR constant, fetch_pkt_t struct {pc, instr}.
- Sub-module fetch_skid_buf: one-entry buffer of fetch_pkt_t with load/unload/clear and full flag, synchronous active-low reset.

Test Plan:
- Reset, memory always grants, 1-cycle rvalid, rdata=addr^32'hA5A5_0000 -> if_id_pc sequence 0,4,8,...; instr matches; if_id_pc4=pc+4.
- stall held 6 cycles mid-stream -> IF/ID frozen, one extra word captured in skid, imem_req low while skid full; after release no word is lost or duplicated.
- Redirect to 32'h0000_0102 while in WAIT -> stale response discarded (DRAIN), next fetch addr 32'h0000_0100, if_id_valid=0 for flush cycle.
- Redirect in same cycle as rvalid, and redirect during stall with skid full -> both data discarded, skid empty, next pc = target.
- RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; if_id_pc4 for FFFF_FFFC is 0.
- rst_n low for 1 cycle during WAIT, old rvalid arrives after -> ignored; first fetch at RESET_PC; outputs match reset values.
